// File: rtl/jtag_debug_cmd_bridge_if.sv
// Command handshake bundle between the debug bridge (master) and its consumer (slave).
//   cmd_valid      : bridge has a command at the FIFO head
//   cmd_ready      : consumer accepts the head command
//   jdo            : data of the last accepted command, held until the next accept
//   take_action    : one-cycle one-hot pulse per IR channel, action bit set
//   take_no_action : one-cycle one-hot pulse per IR channel, action bit clear
interface jtag_debug_cmd_bridge_if #(
  parameter int unsigned DATA_WIDTH = 38,
  parameter int unsigned IR_WIDTH   = 2
);
  localparam int unsigned NCH = 2 ** IR_WIDTH;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] jdo;
  logic [NCH-1:0]        take_action;
  logic [NCH-1:0]        take_no_action;

  modport master (
    output cmd_valid,
    output jdo,
    output take_action,
    output take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  jdo,
    input  take_action,
    input  take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the JTAG debug command path. Synchronises the TCK-domain
// update-DR toggle, captures {ir_in, sr} into a small FIFO and drains it one
// command per accepted handshake, producing a held jdo word and a one-cycle
// per-IR take_action / take_no_action pulse.
//   clk, reset_n     : system clock, synchronous active-low reset
//   udr_toggle       : TCK-domain level, flips once per update-DR
//   sr, ir_in        : TCK-domain shift register / instruction (quasi-static)
//   cmd_if           : command handshake, jdo and decoded pulses
//   fifo_level       : entries currently held
//   overflow         : sticky flag, a command was dropped on a full FIFO
//   overflow_clr     : clears overflow (a coincident drop wins)
module jtag_debug_cmd_bridge #(
  parameter int unsigned DATA_WIDTH  = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          udr_toggle,
  input  logic [DATA_WIDTH-1:0]         sr,
  input  logic [IR_WIDTH-1:0]           ir_in,
  jtag_debug_cmd_bridge_if.master       cmd_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);
  localparam int unsigned NCH   = 2 ** IR_WIDTH;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = IR_WIDTH + DATA_WIDTH;

  // Toggle synchroniser: free-running so its state is settled at reset release
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], udr_toggle};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  logic udr_evt;
  assign udr_evt = reset_n & (sync_q[SYNC_STAGES-1] ^ prev_q);

  // FIFO storage and control state
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [DATA_WIDTH-1:0] jdo_q, jdo_d;
  logic [NCH-1:0]    take_action_q, take_action_d;
  logic [NCH-1:0]    take_no_action_q, take_no_action_d;
  logic              overflow_q, overflow_d;

  logic [ENT_W-1:0]      head;
  logic [IR_WIDTH-1:0]   head_ir;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  pop, push, drop, full;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_ir   = head[ENT_W-1 -: IR_WIDTH];
    head_data = head[DATA_WIDTH-1:0];
    pop       = cmd_valid_q & cmd_if.cmd_ready;
    full      = (level_q == LVL_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge
    drop      = udr_evt & full & ~pop;
    push      = udr_evt & ~drop;
  end

  // Next-state for pointers, level, outputs and pulses
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    level_d          = level_q;
    jdo_d            = jdo_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    overflow_d       = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      jdo_d    = head_data;
      if (head_data[DATA_WIDTH-1]) begin
        take_action_d = NCH'(1) << head_ir;
      end else begin
        take_no_action_d = NCH'(1) << head_ir;
      end
    end

    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end

    cmd_valid_d = (level_d != '0);

    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      level_q          <= '0;
      cmd_valid_q      <= 1'b0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overflow_q       <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      level_q          <= level_d;
      cmd_valid_q      <= cmd_valid_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overflow_q       <= overflow_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by level_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ir_in, sr};
    end
  end

  assign cmd_if.cmd_valid      = cmd_valid_q;
  assign cmd_if.jdo            = jdo_q;
  assign cmd_if.take_action    = take_action_q;
  assign cmd_if.take_no_action = take_no_action_q;
  assign fifo_level            = level_q;
  assign overflow              = overflow_q;
endmodule

// File: tb/tb_jtag_debug_cmd_bridge.sv
module tb_jtag_debug_cmd_bridge;
  localparam int unsigned DW    = 38;
  localparam int unsigned IW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned NCH   = 1 << IW;
  localparam int unsigned W     = DW + IW;
  localparam int          LAT   = SYNC + 1;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    udr_toggle;
  logic [DW-1:0]           sr;
  logic [IW-1:0]           ir_in;
  logic                    overflow_clr;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic                    overflow;

  jtag_debug_cmd_bridge_if #(.DATA_WIDTH(DW), .IR_WIDTH(IW)) cmd_if ();

  jtag_debug_cmd_bridge #(
    .DATA_WIDTH(DW), .IR_WIDTH(IW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .udr_toggle   (udr_toggle),
    .sr           (sr),
    .ir_in        (ir_in),
    .cmd_if       (cmd_if.master),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  // Reference model: command queue plus in-flight toggle events
  logic [W-1:0]   q [$];
  int             pcnt [$];
  logic [W-1:0]   pdat [$];
  logic [DW-1:0]  e_jdo;
  logic [NCH-1:0] e_ta, e_tna;
  logic           e_ovf;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rdy, input bit clr, input bit rst);
    bit pop, push, drop;
    logic [W-1:0] pd, h;
    pop  = (q.size() != 0) && rdy && !rst;
    push = 1'b0;
    pd   = '0;
    foreach (pcnt[i]) pcnt[i]--;
    if (pcnt.size() != 0 && pcnt[0] == 0) begin
      push = !rst;
      pd   = pdat[0];
      void'(pcnt.pop_front());
      void'(pdat.pop_front());
    end
    if (rst) begin
      q.delete();
      e_jdo = '0; e_ta = '0; e_tna = '0; e_ovf = 1'b0;
    end else begin
      e_ta = '0; e_tna = '0; drop = 1'b0;
      if (pop) begin
        h = q.pop_front();
        e_jdo = h[DW-1:0];
        if (h[DW-1]) e_ta = NCH'(1) << h[W-1:DW];
        else         e_tna = NCH'(1) << h[W-1:DW];
      end
      if (push) begin
        if (q.size() == DEPTH) drop = 1'b1;
        else q.push_back(pd);
      end
      if (drop) e_ovf = 1'b1;
      else if (clr) e_ovf = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("level",          64'(fifo_level),            64'(q.size()));
    chk("cmd_valid",      64'(cmd_if.cmd_valid),      64'(q.size() != 0));
    chk("jdo",            64'(cmd_if.jdo),            64'(e_jdo));
    chk("take_action",    64'(cmd_if.take_action),    64'(e_ta));
    chk("take_no_action", 64'(cmd_if.take_no_action), 64'(e_tna));
    chk("overflow",       64'(overflow),              64'(e_ovf));
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1ns later
  task automatic step(input bit flip, input logic [DW-1:0] s, input logic [IW-1:0] ir,
                      input bit rdy, input bit clr, input bit rst);
    if (flip) begin
      udr_toggle = ~udr_toggle;
      sr = s;
      ir_in = ir;
      pcnt.push_back(LAT);
      pdat.push_back({ir, s});
    end
    cmd_if.cmd_ready = rdy;
    overflow_clr     = clr;
    reset_n          = ~rst;
    @(posedge clk);
    model_edge(rdy, clr, rst);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic push_cmd(input logic [DW-1:0] s, input logic [IW-1:0] ir, input bit rdy);
    step(1'b1, s, ir, rdy, 1'b0, 1'b0);
    idle(3, rdy);
  endtask

  initial begin
    int gap;
    bit flip, rdy, clr;
    reset_n = 1'b0; udr_toggle = 1'b1; sr = '0; ir_in = '0;
    overflow_clr = 1'b0; cmd_if.cmd_ready = 1'b0;
    e_jdo = '0; e_ta = '0; e_tna = '0; e_ovf = 1'b0;

    // Reset with toggle held high, then quiet release
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b0);

    // Action command on channel 2
    step(1'b1, 38'h20_0000_0001, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_valid_edge2", 64'(cmd_if.cmd_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_valid_edge3", 64'(cmd_if.cmd_valid), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_jdo", 64'(cmd_if.jdo), 64'h20_0000_0001);
    chk("t2_take_action", 64'(cmd_if.take_action), 64'b0100);
    chk("t2_take_no_action", 64'(cmd_if.take_no_action), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_pulse_end", 64'(cmd_if.take_action), 64'd0);

    // No-action command on channel 1
    push_cmd(38'h00_DEAD_BEEF, 2'd1, 1'b1);
    chk("t3_take_no_action", 64'(cmd_if.take_no_action), 64'b0010);
    idle(3, 1'b1);
    chk("t3_jdo_held", 64'(cmd_if.jdo), 64'h00_DEAD_BEEF);

    // Overflow: five commands into a four-deep FIFO, then drain and clear
    for (int k = 1; k <= 5; k++) push_cmd(DW'(k), 2'd0, 1'b0);
    chk("t4_level_full", 64'(fifo_level), 64'd4);
    chk("t4_overflow", 64'(overflow), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_jdo_seq", 64'(cmd_if.jdo), 64'(k));
    end
    chk("t4_level_empty", 64'(fifo_level), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("t4_overflow_clr", 64'(overflow), 64'd0);

    // Full FIFO with push and pop on the same edge
    for (int k = 0; k < 4; k++) push_cmd(DW'(16 + k), IW'(k), 1'b0);
    step(1'b1, 38'h3F_0000_00AA, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t5_level", 64'(fifo_level), 64'd4);
    chk("t5_overflow", 64'(overflow), 64'd0);
    idle(6, 1'b1);
    chk("t5_last_out", 64'(cmd_if.jdo), 64'h3F_0000_00AA);

    // Reset mid-operation with three entries held
    for (int k = 0; k < 3; k++) push_cmd(DW'(32 + k), IW'(k), 1'b0);
    chk("t6_level3", 64'(fifo_level), 64'd3);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("t6_level0", 64'(fifo_level), 64'd0);
    chk("t6_jdo0", 64'(cmd_if.jdo), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t6_no_pulse", 64'(cmd_if.take_action | cmd_if.take_no_action), 64'd0);

    // Randomised traffic against the model
    gap = 4;
    for (int i = 0; i < 600; i++) begin
      flip = (gap >= 4) && ($urandom_range(0, 1) == 1);
      rdy  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      step(flip, DW'({$urandom(), $urandom()}), IW'($urandom()), rdy, clr, 1'b0);
      gap = flip ? 1 : gap + 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
